// File: rtl/enigma_ctrl_pkg.sv
// Shared types and constants for the ENIGMA session controller.
// State encoding, rotor geometry and crypt mode values.
package enigma_ctrl_pkg;

  localparam int ROTOR_LEN = 128;
  localparam int SYM_W     = 6;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LOAD,
    GAP,
    CODE,
    DRAIN,
    ABORT,
    ARB_NEXT
  } state_e;

endpackage

// File: rtl/enigma_rr_arb.sv
// Round-robin one-hot picker: first asserted request
// found scanning upward from ptr, wrapping at N.
module enigma_rr_arb #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  int i;

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    i      = 0;
    for (int k = 0; k < N; k++) begin
      i = (int'(ptr) + k) % N;
      if (!any && req[i]) begin
        any       = 1'b1;
        idx       = IW'(i);
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enigma_session_ctrl.sv
// Shares one ENIGMA core between N_REQ requesters:
// arbitrates, streams the rotor load and code words, routes results.
module enigma_session_ctrl #(
  parameter int N_REQ    = 2,
  parameter int CNT_W    = 8,
  parameter int DRAIN_TO = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_mode,
  input  logic [N_REQ-1:0]   s_valid,
  input  logic [6*N_REQ-1:0] s_data,
  input  logic [N_REQ-1:0]   s_last,
  output logic [N_REQ-1:0]   s_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [5:0]         rsp_code,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               enc_in_valid,
  output logic               enc_in_valid_2,
  output logic               enc_crypt_mode,
  output logic [5:0]         enc_code_in,
  input  logic               enc_out_valid,
  input  logic [5:0]         enc_out_code
);

  import enigma_ctrl_pkg::*;

  localparam int IW = $clog2(N_REQ);
  localparam int LW = $clog2(ROTOR_LEN);
  localparam int DW = $clog2(DRAIN_TO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e state_q, state_d;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             mode_q, mode_d;
  logic [LW-1:0]    load_q, load_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic [DW-1:0]    drain_q, drain_d;

  logic             iv_q, iv_d;
  logic             iv2_q, iv2_d;
  logic             cm_q, cm_d;
  logic [SYM_W-1:0] ci_q, ci_d;
  logic [N_REQ-1:0] rv_q, rv_d;
  logic [SYM_W-1:0] rc_q, rc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             arb_any;
  logic [IW-1:0]    arb_idx;
  logic [N_REQ-1:0] arb_oh;

  enigma_rr_arb #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .any    (arb_any),
    .idx    (arb_idx),
    .onehot (arb_oh)
  );

  logic             stream_st;
  logic             beat;
  logic             sel_last;
  logic [SYM_W-1:0] sel_data;
  logic             load_end;
  logic             code_end;
  logic             drain_ok;
  logic             drain_exp;
  logic             rsp_st;

  assign stream_st = (state_q == LOAD) || (state_q == CODE);
  assign s_ready   = grant_q & {N_REQ{stream_st}};
  assign beat      = |(s_valid & s_ready);
  assign sel_last  = s_last[win_q];
  assign sel_data  = s_data[int'(win_q)*SYM_W +: SYM_W];
  assign load_end  = load_q == LW'(ROTOR_LEN - 1);
  // saturated count doubles as an implicit last word
  assign code_end  = beat && (sel_last || sent_q == CNT_MAX - 1'b1);
  assign drain_ok  = recv_q == sent_q;
  assign drain_exp = !enc_out_valid && drain_q == DW'(DRAIN_TO - 1);
  assign rsp_st    = (state_q == CODE) || (state_q == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (|req) state_d = GRANT;
      GRANT:    state_d = arb_any ? LOAD : IDLE;
      LOAD: begin
        if (!beat)         state_d = ABORT;
        else if (load_end) state_d = GAP;
      end
      GAP:      state_d = CODE;
      CODE:     if (code_end) state_d = DRAIN;
      DRAIN: begin
        if (drain_ok)       state_d = ARB_NEXT;
        else if (drain_exp) state_d = ABORT;
      end
      ABORT:    state_d = ARB_NEXT;
      ARB_NEXT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    mode_d  = mode_q;
    load_d  = load_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    drain_d = drain_q;
    iv_d    = 1'b0;
    iv2_d   = 1'b0;
    cm_d    = ENC;
    ci_d    = '0;
    rv_d    = '0;
    rc_d    = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      GRANT: begin
        win_d   = arb_idx;
        grant_d = arb_oh;
        mode_d  = req_mode[arb_idx];
        load_d  = '0;
        sent_d  = '0;
        recv_d  = '0;
        drain_d = '0;
      end
      LOAD: begin
        if (beat) begin
          iv_d   = 1'b1;
          cm_d   = (load_q == '0) ? mode_q : ENC;
          ci_d   = sel_data;
          load_d = load_q + 1'b1;
        end else begin
          err_d   = 1'b1;
          grant_d = '0;
        end
      end
      CODE: begin
        drain_d = '0;
        if (beat) begin
          iv2_d = 1'b1;
          ci_d  = sel_data;
          if (sent_q != CNT_MAX) sent_d = sent_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_ok) begin
          done_d  = 1'b1;
          grant_d = '0;
        end else if (drain_exp) begin
          err_d   = 1'b1;
          grant_d = '0;
        end else begin
          drain_d = enc_out_valid ? '0 : drain_q + 1'b1;
        end
      end
      ARB_NEXT: begin
        ptr_d = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: ;
    endcase
    if (enc_out_valid && rsp_st) begin
      rv_d = grant_q;
      rc_d = enc_out_code;
      if (recv_q != CNT_MAX) recv_d = recv_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      mode_q  <= 1'b0;
      load_q  <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      drain_q <= '0;
      iv_q    <= 1'b0;
      iv2_q   <= 1'b0;
      cm_q    <= 1'b0;
      ci_q    <= '0;
      rv_q    <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      mode_q  <= mode_d;
      load_q  <= load_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      drain_q <= drain_d;
      iv_q    <= iv_d;
      iv2_q   <= iv2_d;
      cm_q    <= cm_d;
      ci_q    <= ci_d;
      rv_q    <= rv_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign grant          = grant_q;
  assign rsp_valid      = rv_q;
  assign rsp_code       = rc_q;
  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign err            = err_q;
  assign enc_in_valid   = iv_q;
  assign enc_in_valid_2 = iv2_q;
  assign enc_crypt_mode = cm_q;
  assign enc_code_in    = ci_q;

endmodule
